// File: rtl/reg_native_if2apb.sv
// Register native interface to APB4 requester bridge; one transaction at a time in the pclk domain.
// Optional ACCESS-phase timeout is built when REG_NATIVE_IF2APB_TIMEOUT_EN is defined.
module reg_native_if2apb #(
    parameter int ADDR_WIDTH     = 48,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_vld,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    non_sec,
    output logic                    ack_vld,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    write_q;
    logic                    non_sec_q;
    logic [DATA_WIDTH-1:0]   rd_data_d;
    logic                    err_d;
    logic                    req_legal;
    logic                    timeout;

    assign req_legal = req_vld && (wr_en ^ rd_en);

`ifdef REG_NATIVE_IF2APB_TIMEOUT_EN
    logic [15:0] wait_cnt_q;

    // Fires on the ACCESS cycle that would bring the low-pready count up to the limit.
    assign timeout = (state_q == ACCESS) && !pready
                  && (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt_q <= '0;
        end else if (state_q == IDLE && req_legal) begin
            wait_cnt_q <= '0;
        end else if (state_q == ACCESS && !pready) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data;
        err_d     = err;
        case (state_q)
            IDLE: begin
                if (req_legal) begin
                    state_d = SETUP;
                end else if (req_vld) begin
                    state_d   = RESP;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_d   = RESP;
                    err_d     = pslverr;
                    rd_data_d = write_q ? '0 : prdata;
                end else if (timeout) begin
                    state_d   = RESP;
                    err_d     = 1'b1;
                    rd_data_d = '0;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            rd_data <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_data <= rd_data_d;
            err     <= err_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            non_sec_q <= 1'b0;
        end else if (state_q == IDLE && req_legal) begin
            addr_q    <= addr;
            wdata_q   <= wr_data;
            write_q   <= wr_en;
            non_sec_q <= non_sec;
        end
    end

    // APB outputs decode only registered state, so nothing combinational reaches them from inputs.
    assign psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable = (state_q == ACCESS);
    assign pwrite  = psel && write_q;
    assign paddr   = psel ? addr_q  : '0;
    assign pwdata  = psel ? wdata_q : '0;
    assign pstrb   = (psel && write_q) ? '1 : '0;
    assign pprot   = {1'b0, psel && non_sec_q, 1'b0};
    assign ack_vld = (state_q == RESP);

endmodule
